// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared state encoding and sizing for the Booth multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MULT_ITER = 32;
    localparam int ACC_W     = 33;

    function automatic logic [ACC_W-1:0] sext33(input logic [31:0] v);
        return {v[31], v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_addsub33.sv
// ============================================================================
// Module      : booth_addsub33
// Description : 33-bit modular adder/subtractor, sum = a + (b ^ {33{sub}}) + sub.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_addsub33
    import mult_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic             sub,
    output logic [ACC_W-1:0] sum
);

    logic [ACC_W-1:0] w_b_inv;

    assign w_b_inv = b ^ {ACC_W{sub}};
    assign sum     = a + w_b_inv + {{(ACC_W-1){1'b0}}, sub};

endmodule

`default_nettype wire

// File: rtl/booth_mult_ctrl.sv
// ============================================================================
// Module      : booth_mult_ctrl
// Description : Radix-2 Booth 32x32 signed multiplier, 32 cycles per product.
//               Optional macro MULT_ZERO_BYPASS_EN: zero operands skip to DONE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mult_ctrl
    import mult_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        result_rdy,
    output logic [31:0] result,
    output logic        overflow
);

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_m;
    logic [ACC_W-1:0] r_acc;
    logic [31:0]      r_q;
    logic             r_q_m1;
    logic [4:0]       r_cnt;
    logic [31:0]      r_result;
    logic             r_overflow;

    logic             w_accept;
    logic             w_zero;
    logic             w_last;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_acc_op;
    logic [ACC_W-1:0] w_acc_sh;
    logic [31:0]      w_q_sh;

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_cnt == 5'(MULT_ITER - 1));

`ifdef MULT_ZERO_BYPASS_EN
    assign w_zero = (op_a == 32'd0) || (op_b == 32'd0);
`else
    assign w_zero = 1'b0;
`endif

    // {q[0], q_m1} = 10 subtracts M, 01 adds M, otherwise acc passes through.
    booth_addsub33 u_addsub (
        .a   (r_acc),
        .b   (sext33(r_m)),
        .sub (r_q[0]),
        .sum (w_sum)
    );

    assign w_acc_op = (r_q[0] ^ r_q_m1) ? w_sum : r_acc;
    assign w_acc_sh = {w_acc_op[ACC_W-1], w_acc_op[ACC_W-1:1]};
    assign w_q_sh   = {w_acc_op[0], r_q[31:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next = w_zero ? DONE : RUN;
            end
            RUN: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                if (start) w_next = w_zero ? DONE : RUN;
                else       w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_m        <= 32'd0;
            r_acc      <= '0;
            r_q        <= 32'd0;
            r_q_m1     <= 1'b0;
            r_cnt      <= 5'd0;
            r_result   <= 32'd0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_m    <= op_a;
            r_acc  <= '0;
            r_q    <= op_b;
            r_q_m1 <= 1'b0;
            r_cnt  <= 5'd0;
            if (w_zero) begin
                r_result   <= 32'd0;
                r_overflow <= 1'b0;
            end
        end else if (r_state == RUN) begin
            r_acc  <= w_acc_sh;
            r_q    <= w_q_sh;
            r_q_m1 <= r_q[0];
            r_cnt  <= r_cnt + 5'd1;
            if (w_last) begin
                // Product fits in 32 bits only if the upper 33 bits are pure sign extension.
                r_result   <= w_q_sh;
                r_overflow <= (w_acc_sh != {ACC_W{w_q_sh[31]}});
            end
        end
    end

    assign busy       = (r_state == RUN);
    assign result_rdy = (r_state == DONE);
    assign result     = r_result;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_booth_mult_ctrl.sv
// ============================================================================
// Module      : tb_booth_mult_ctrl
// Description : Scoreboard bench for booth_mult_ctrl with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_mult_ctrl;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        result_rdy;
    logic [31:0] result;
    logic        overflow;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          lat;
        int          bsy;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;
    int   cyc;
    int   busy_cnt;

`ifdef MULT_ZERO_BYPASS_EN
    localparam int ZLAT  = 1;
    localparam int ZBUSY = 0;
`else
    localparam int ZLAT  = 32;
    localparam int ZBUSY = 32;
`endif

    booth_mult_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .result_rdy (result_rdy),
        .result     (result),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per result_rdy cycle.
    initial begin
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (result_rdy) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rdy", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("result",   result,             e.res);
                        check("overflow", {31'd0, overflow},  {31'd0, e.ovf});
                        check("latency",  cyc - e.acc_cyc,    e.lat);
                        check("busy_cyc", busy_cnt,           e.bsy);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic push(input logic [31:0] r, input logic o, input int lat, input int bsy);
        exp_t e;
        e.res = r; e.ovf = o; e.lat = lat; e.bsy = bsy; e.acc_cyc = cyc;
        sb.push_back(e);
    endtask

    // Drive start for one edge, record the accept, then release start.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic o, input int lat, input int bsy);
        @(negedge clock);
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clock);
        #1 push(r, o, lat, bsy);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
        @(negedge clock);
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        n_cmp = 0; n_err = 0; cyc = 0;
        reset_n = 1'b0; start = 1'b0; op_a = 32'd0; op_b = 32'd0;
        repeat (3) @(negedge clock);
        check("rst_busy",     {31'd0, busy},       32'd0);
        check("rst_rdy",      {31'd0, result_rdy}, 32'd0);
        check("rst_result",   result,              32'd0);
        check("rst_overflow", {31'd0, overflow},   32'd0);
        reset_n = 1'b1;

        issue(32'd3, 32'd4, 32'h0000000C, 1'b0, 32, 32);                 drain();
        issue(-32'sd7, 32'd6, 32'hFFFFFFD6, 1'b0, 32, 32);               drain();
        issue(32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, 32, 32);          drain();
        issue(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 32, 32);   drain();
        issue(32'h80000000, 32'd1, 32'h80000000, 1'b0, 32, 32);          drain();

        // start pulsed mid-RUN with different operands must be ignored
        issue(32'd12345, 32'd1000, 32'h00BC5EA8, 1'b0, 32, 32);
        repeat (5) @(negedge clock);
        op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drain();

        // start held through DONE: back-to-back accept
        @(negedge clock);
        op_a = 32'd100; op_b = -32'sd3; start = 1'b1;
        @(posedge clock);
        #1 push(32'hFFFFFED4, 1'b0, 32, 32);
        for (i = 0; i < 60 && !result_rdy; i++) @(negedge clock);
        if (!result_rdy) @(negedge clock);
        op_a = 32'h00010000; op_b = 32'h00010000;
        @(posedge clock);
        #1 push(32'h00000000, 1'b1, 32, 32);
        @(negedge clock);
        start = 1'b0;
        drain();

        // reset at iteration 10 aborts; outputs clear asynchronously
        @(negedge clock);
        op_a = 32'd3; op_b = 32'd4; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("abort_busy",     {31'd0, busy},       32'd0);
        check("abort_rdy",      {31'd0, result_rdy}, 32'd0);
        check("abort_result",   result,              32'd0);
        check("abort_overflow", {31'd0, overflow},   32'd0);
        repeat (3) @(negedge clock);
        op_a = 32'd5; op_b = 32'd5; start = 1'b1;
        reset_n = 1'b1;
        @(posedge clock);
        #1 push(32'd25, 1'b0, 32, 32);
        @(negedge clock);
        start = 1'b0;
        drain();

        issue(32'd0, 32'h12345678, 32'd0, 1'b0, ZLAT, ZBUSY);            drain();
        issue(32'h12345678, 32'd0, 32'd0, 1'b0, ZLAT, ZBUSY);            drain();

        repeat (5) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/booth_mult_ctrl.md
BOOTH_MULT_CTRL -- requirements
Module: booth_mult_ctrl

Interface
REQ-001 The block SHALL have no parameters; the operand and result width is fixed at 32 bits.
REQ-002 The block SHALL use one clock with an asynchronous, active-low reset, with ports named as follows.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a multiply; sampled on a rising clock edge.
REQ-006 op_a  input  32  multiplicand, two's complement; sampled with start.
REQ-007 op_b  input  32  multiplier, two's complement; sampled with start.
REQ-008 busy  output  1  high while the state is RUN.
REQ-009 result_rdy  output  1  one-cycle pulse; result and overflow are valid.
REQ-010 result  output  32  low 32 bits of the signed 64-bit product; held until the next accept.
REQ-011 overflow  output  1  product is not representable in 32 signed bits; held with result.

Function
REQ-012 The block SHALL implement radix-2 Booth multiplication using the states IDLE, RUN and DONE.
REQ-013 IDLE or DONE with start=1 at an edge SHALL perform an accept:
- M <= op_a;
- acc (33-bit) <= 0;
- q <= op_b;
- q_m1 <= 0;
- cnt <= 0;
- next state RUN.
REQ-014 In RUN, each edge SHALL select an operation from {q[0], q_m1}:
- 01: acc + sext33(M);
- 10: acc - sext33(M);
- 00 and 11: acc unchanged.
REQ-015 The same RUN edge SHALL then arithmetic-shift {acc, q, q_m1} right by one and increment cnt.
REQ-016 The RUN edge with cnt=31 SHALL complete the 32nd iteration and enter DONE.
REQ-017 On entry to DONE, result SHALL be loaded with q after the final shift.
REQ-018 On entry to DONE, overflow SHALL be set unless every bit of acc[32:0] equals the final q[31].
REQ-019 result_rdy SHALL be high exactly during the DONE cycle, i.e. 32 cycles after the accepting edge.
REQ-020 DONE SHALL go to IDLE at the next edge unless start=1, in which case it performs a back-to-back accept.
REQ-021 start during RUN SHALL be ignored, with no effect on the operation in progress.
REQ-022 All add and subtract operations SHALL be 33-bit modular; the M=0x80000000 subtract case SHALL be exact thanks to the 33rd bit.

Reset
REQ-023 reset_n=0 SHALL immediately force the following, regardless of current state:
- state IDLE;
- busy=0, result_rdy=0;
- result=0, overflow=0;
- cnt, acc, q, q_m1 and M all cleared.
REQ-024 A reset asserted mid-RUN SHALL abort the operation; no result_rdy pulse SHALL follow.
REQ-025 The first accept SHALL be possible at the first rising edge after reset_n deasserts.

Configuration
REQ-026 With macro MULT_ZERO_BYPASS_EN defined, an accept with op_a=0 or op_b=0 SHALL go directly to DONE at the next edge.
REQ-027 On that zero bypass, result=0 and overflow=0, with result_rdy one cycle after the accept; busy SHALL never assert.
REQ-028 Without MULT_ZERO_BYPASS_EN, zero operands SHALL take the full 32-iteration path.

Structure
REQ-029 Shared package mult_pkg SHALL hold:
- the state encoding (IDLE, RUN, DONE);
- MULT_ITER=32;
- ACC_W=33.
REQ-030 The 33-bit add/subtract SHALL be a single sub-module, booth_addsub33.
REQ-031 booth_addsub33 SHALL have inputs a, b and sub, and output sum.
REQ-032 booth_addsub33 SHALL compute a + (b XOR {33{sub}}) + sub.
REQ-033 The controller SHALL instantiate booth_addsub33 exactly once.

Verification
REQ-034 The bench SHALL cover the directed scenarios below.
- 3 x 4: result=0x0000000C, overflow=0; result_rdy exactly 32 cycles after the accept; busy high for 32 cycles.
- -7 x 6: result=0xFFFFFFD6, overflow=0.
- 0x7FFFFFFF x 2: result=0xFFFFFFFE, overflow=1.
- 0x80000000 x 0xFFFFFFFF: result=0x80000000, overflow=1.
- 0x80000000 x 1: result=0x80000000, overflow=0.
- start pulsed mid-RUN: ignored.
- start held through DONE: back-to-back accept; second result correct.
- reset_n low at iteration 10: all outputs 0 immediately; no result_rdy; next multiply 5 x 5 = 25.
- 0 x 0x12345678, with MULT_ZERO_BYPASS_EN: result_rdy 1 cycle after the accept, result=0.
- 0 x 0x12345678, without MULT_ZERO_BYPASS_EN: result_rdy after 32 cycles, result=0.
